// File: rtl/vending_ctrl_param_if.sv
// Vending controller bus: coin/selection/control inputs and the
// credit, dispense, change and status outputs.
interface vending_ctrl_param_if #(
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = 6
);
  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  logic                M1;
  logic                M2;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel;
  logic                cancel;
  logic                restock;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic [SEL_W-1:0]    bebida;
  logic [CREDIT_W-1:0] change;
  logic                change_valid;
  logic                to;
  logic                sold_out;
  logic                coin_reject;
  logic [1:0]          state;

  modport master (
    output M1, M2, sel_valid, sel, cancel, restock,
    input  credit, dispense, bebida, change, change_valid, to, sold_out, coin_reject, state
  );

  modport slave (
    input  M1, M2, sel_valid, sel, cancel, restock,
    output credit, dispense, bebida, change, change_valid, to, sold_out, coin_reject, state
  );
endinterface

// File: rtl/vending_ctrl_param.sv
// Parameterised vending controller: coin collection with overflow reject,
// priced product selection with per-product stock, change return and idle timeout.
module vending_ctrl_param #(
  parameter int N_PROD      = 4,
  parameter int CREDIT_W    = 6,
  parameter int COIN1_VAL   = 1,
  parameter int COIN2_VAL   = 5,
  parameter int BASE_PRICE  = 3,
  parameter int PRICE_STEP  = 2,
  parameter int STOCK_INIT  = 2,
  parameter int STOCK_W     = 4,
  parameter int TIMEOUT_CYC = 50
) (
  input logic                 clk,
  input logic                 reset,
  vending_ctrl_param_if.slave bus
);
  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [31:0] CREDIT_MAX = 32'((64'd1 << CREDIT_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_q;
  logic [SEL_W-1:0]    bebida_q;
  logic                dispense_q;
  logic                change_valid_q;
  logic                to_q;
  logic                sold_out_q;
  logic                coin_reject_q;
  logic [CNT_W-1:0]    idle_cnt;
  logic [STOCK_W-1:0]  stock [N_PROD];

  logic        coin_in;
  logic [31:0] coin_val;
  logic [31:0] credit_sum;
  logic [31:0] sel_price;
  logic        coin_fits;
  logic        sel_in_range;
  logic        sel_stocked;
  logic        sel_afford;
  logic        idle_expired;

  function automatic logic [31:0] price_of(input logic [SEL_W-1:0] idx);
    return 32'(BASE_PRICE) + 32'(idx) * 32'(PRICE_STEP);
  endfunction

  // Coin value, overflow test and selection qualification.
  always_comb begin
    coin_in      = bus.M1 | bus.M2;
    coin_val     = (bus.M1 ? 32'(COIN1_VAL) : 32'd0) + (bus.M2 ? 32'(COIN2_VAL) : 32'd0);
    credit_sum   = 32'(credit_q) + coin_val;
    coin_fits    = (credit_sum <= CREDIT_MAX);
    sel_in_range = (32'(bus.sel) < 32'(N_PROD));
    sel_price    = price_of(bus.sel);
    sel_afford   = (32'(credit_q) >= sel_price);
    idle_expired = (32'(idle_cnt) >= 32'(TIMEOUT_CYC - 1));
    if (sel_in_range) begin
      sel_stocked = (stock[bus.sel] != STOCK_W'(0));
    end else begin
      sel_stocked = 1'b0;
    end
  end

  // Transaction FSM with all outputs and stock counters registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      bebida_q       <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      to_q           <= 1'b0;
      sold_out_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      idle_cnt       <= '0;
      for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      to_q           <= 1'b0;
      sold_out_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_cnt <= '0;
          if (coin_in) begin
            if (coin_fits) begin
              credit_q <= CREDIT_W'(credit_sum);
              state_q  <= COLLECT;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
          if (bus.restock) begin
            for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
          end
        end
        COLLECT: begin
          if (bus.cancel) begin
            idle_cnt       <= '0;
            change_q       <= credit_q;
            change_valid_q <= 1'b1;
            credit_q       <= '0;
            state_q        <= CHANGE;
          end else if (coin_in) begin
            idle_cnt <= '0;
            if (coin_fits) begin
              credit_q <= CREDIT_W'(credit_sum);
            end else begin
              coin_reject_q <= 1'b1;
            end
          end else if (bus.sel_valid) begin
            idle_cnt <= '0;
            if (sel_in_range) begin
              if (!sel_stocked) begin
                sold_out_q <= 1'b1;
              end else if (sel_afford) begin
                // Credit and stock are charged on entry so DISPENSE already shows the remainder.
                dispense_q     <= 1'b1;
                bebida_q       <= bus.sel;
                credit_q       <= credit_q - CREDIT_W'(sel_price);
                stock[bus.sel] <= stock[bus.sel] - STOCK_W'(1);
                state_q        <= DISPENSE;
              end
            end
          end else if (idle_expired) begin
            idle_cnt       <= '0;
            to_q           <= 1'b1;
            change_q       <= credit_q;
            change_valid_q <= 1'b1;
            credit_q       <= '0;
            state_q        <= CHANGE;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        DISPENSE: begin
          coin_reject_q  <= coin_in;
          change_q       <= credit_q;
          change_valid_q <= 1'b1;
          credit_q       <= '0;
          state_q        <= CHANGE;
        end
        CHANGE: begin
          coin_reject_q <= coin_in;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.credit       = credit_q;
  assign bus.change       = change_q;
  assign bus.bebida       = bebida_q;
  assign bus.dispense     = dispense_q;
  assign bus.change_valid = change_valid_q;
  assign bus.to           = to_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.state        = state_q;
endmodule
